// File: rtl/ring_freq_meter_pkg.sv
// Shared types and default constants for the ring oscillator frequency meter.
package ring_meas_pkg;

  // Measurement sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GATE   = 2'd2
  } meas_state_t;

  // Shortest gate is 2^GATE_MIN_LOG2 clk cycles.
  localparam int GATE_MIN_LOG2_DEF = 8;
  // Ring run-in time before counting; also hides the synchronizer latency.
  localparam int SETTLE_CYC_DEF    = 8;
  // Default result width.
  localparam int CNT_W_DEF         = 16;

endpackage

// File: rtl/sync_rise_det.sv
// Two-flop synchronizer followed by an edge-detect flop.
// Produces a one-cycle rise pulse per synchronized 0->1 transition of d.
module sync_rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic s1_q, s2_q, s3_q;

  // Shift the asynchronous input through the synchronizer and history flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/ring_freq_meter.sv
// Frequency meter for the tapped ring oscillator: enables the ring, lets it
// settle, counts synchronized rising edges over a 2^n-cycle gate and holds
// the saturated result with a level valid flag.
module ring_freq_meter
  import ring_meas_pkg::*;
#(
  parameter int CNT_W         = CNT_W_DEF,
  parameter int GATE_MIN_LOG2 = GATE_MIN_LOG2_DEF,
  parameter int SETTLE_CYC    = SETTLE_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       gate_sel,
  input  logic [3:0]       tap_sel,
  input  logic             osc_in,
  output logic             ring_ena,
  output logic [3:0]       ring_tap,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  // Wide enough for the longest gate (gate_sel = 7) with one spare bit.
  localparam int TW = GATE_MIN_LOG2 + 8;

  meas_state_t      state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [2:0]       gsel_q, gsel_d;
  logic             ring_ena_q, ring_ena_d;
  logic [3:0]       ring_tap_q, ring_tap_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             rise;
  logic [7:0]       gate_shamt;
  logic [TW-1:0]    gate_last;
  logic [CNT_W-1:0] edge_sat;

  sync_rise_det u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (osc_in),
    .rise  (rise)
  );

  // Gate terminal count G-1 as a low-ones mask, and the saturating edge sum.
  always_comb begin
    gate_shamt = 8'(GATE_MIN_LOG2) + {5'd0, gsel_q};
    gate_last  = ~({TW{1'b1}} << gate_shamt);
    edge_sat   = (&edge_cnt_q) ? edge_cnt_q : edge_cnt_q + CNT_W'(rise);
  end

  // Next-state and output-register logic of the measurement sequencer.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    edge_cnt_d = edge_cnt_q;
    gsel_d     = gsel_q;
    ring_ena_d = ring_ena_q;
    ring_tap_d = ring_tap_q;
    valid_d    = valid_q;
    count_d    = count_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SETTLE;
          gsel_d     = gate_sel;
          ring_tap_d = tap_sel;
          valid_d    = 1'b0;
          edge_cnt_d = '0;
          timer_d    = '0;
          ring_ena_d = 1'b1;
        end
      end
      SETTLE: begin
        // Rise pulses are ignored here; the ring and synchronizer warm up.
        timer_d = timer_q + TW'(1);
        if (timer_q == TW'(SETTLE_CYC - 1)) begin
          state_d = GATE;
          timer_d = '0;
        end
      end
      GATE: begin
        edge_cnt_d = edge_sat;
        timer_d    = timer_q + TW'(1);
        if (timer_q == gate_last) begin
          // Include the rise seen in the last gate cycle in the result.
          count_d    = edge_sat;
          valid_d    = 1'b1;
          ring_ena_d = 1'b0;
          timer_d    = '0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial measurement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      edge_cnt_q <= '0;
      gsel_q     <= '0;
      ring_ena_q <= 1'b0;
      ring_tap_q <= '0;
      valid_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      edge_cnt_q <= edge_cnt_d;
      gsel_q     <= gsel_d;
      ring_ena_q <= ring_ena_d;
      ring_tap_q <= ring_tap_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
    end
  end

  assign ring_ena = ring_ena_q;
  assign ring_tap = ring_tap_q;
  assign busy     = (state_q != IDLE);
  assign valid    = valid_q;
  assign count    = count_q;

endmodule

// File: tb/tb_ring_freq_meter.sv
// Self-checking bench for ring_freq_meter: table of measurements plus
// hand-written busy-protection, mid-gate reset and saturation sequences.
`timescale 1ns/100ps
module tb_ring_freq_meter;

  localparam int S = 8;   // settle cycles
  localparam int GMIN = 256; // shortest gate

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // Main DUT (16-bit result)
  logic        start = 1'b0;
  logic [2:0]  gate_sel = 3'd0;
  logic [3:0]  tap_sel = 4'd0;
  logic        ring_ena, busy, valid;
  logic [3:0]  ring_tap;
  logic [15:0] count;

  // Saturation DUT (6-bit result)
  logic        start_s = 1'b0;
  logic [2:0]  gate_sel_s = 3'd0;
  logic [3:0]  tap_sel_s = 4'd0;
  logic        ring_ena_s, busy_s, valid_s;
  logic [3:0]  ring_tap_s;
  logic [5:0]  count_s;

  // Ring oscillator model: toggles every osc_half ns, or holds osc_static.
  int   osc_half = 0;
  logic osc_tgl = 1'b0;
  logic osc_static = 1'b0;
  logic osc_in;
  assign osc_in = (osc_half == 0) ? osc_static : osc_tgl;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int tap;
    int cmin;
    int cmax;
    int lat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int gsel;
    int tap;
    int half;
    int lvl;
    int cmin;
    int cmax;
    int lat;
  } vec_t;
  vec_t vecs[5];

  ring_freq_meter #(.CNT_W(16), .GATE_MIN_LOG2(8), .SETTLE_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .gate_sel(gate_sel),
    .tap_sel(tap_sel), .osc_in(osc_in), .ring_ena(ring_ena),
    .ring_tap(ring_tap), .busy(busy), .valid(valid), .count(count)
  );

  ring_freq_meter #(.CNT_W(6), .GATE_MIN_LOG2(8), .SETTLE_CYC(8)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start_s), .gate_sel(gate_sel_s),
    .tap_sel(tap_sel_s), .osc_in(osc_in), .ring_ena(ring_ena_s),
    .ring_tap(ring_tap_s), .busy(busy_s), .valid(valid_s), .count(count_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #0.3;
    forever begin
      if (osc_half == 0) #1;
      else begin
        #(osc_half);
        osc_tgl = ~osc_tgl;
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_rng(input string nm, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", nm, act, lo, hi, cyc);
    end
  endtask

  // Issue a start on the main DUT; t0 is the cycle index of the accepting edge.
  task automatic launch(input int gsel, input int tap, input int cmin, input int cmax,
                        output int t0);
    exp_t e;
    @(negedge clk);
    gate_sel = 3'(gsel);
    tap_sel  = 4'(tap);
    start    = 1'b1;
    e.tap = tap; e.cmin = cmin; e.cmax = cmax; e.lat = S + (GMIN << gsel);
    sb.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    gate_sel = 3'($urandom_range(7));
    tap_sel  = 4'($urandom_range(15));
    t0 = cyc;
    chk("start_busy", busy, 1);
    chk("start_ring_ena", ring_ena, 1);
    chk("start_ring_tap", ring_tap, tap);
    chk("start_valid_clr", valid, 0);
  endtask

  // Wait for valid and compare against the oldest scoreboard entry.
  task automatic collect(input int t0);
    exp_t e;
    int   bad = 0;
    bit   got = 0;
    int   lim;
    lim = (sb.size() != 0) ? sb[0].lat + 20 : 20;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (valid) begin
        got = 1;
        break;
      end
      if (!busy || !ring_ena) bad++;
    end
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: result with no expectation (cycle %0d)", cyc);
      return;
    end
    e = sb.pop_front();
    if (!got) begin
      errors++;
      $display("FAIL valid_timeout: got no valid expected valid within %0d cycles", lim);
      return;
    end
    chk("latency", cyc - t0, e.lat);
    chk_rng("count", count, e.cmin, e.cmax);
    chk("done_ring_tap", ring_tap, e.tap);
    chk("done_busy", busy, 0);
    chk("done_ring_ena", ring_ena, 0);
    chk("busy_held_during_meas", bad, 0);
    $display("meas tap=%0d count=%0d latency=%0d", ring_tap, count, cyc - t0);
  endtask

  initial begin
    int t0;
    int bad;
    int lat;
    bit got;

    vecs[0] = '{gsel: 0, tap: 5,  half: 40, lvl: 0, cmin: 31, cmax: 33, lat: 264};
    vecs[1] = '{gsel: 1, tap: 3,  half: 40, lvl: 0, cmin: 63, cmax: 65, lat: 520};
    vecs[2] = '{gsel: 2, tap: 12, half: 0,  lvl: 1, cmin: 0,  cmax: 0,  lat: 1032};
    vecs[3] = '{gsel: 0, tap: 10, half: 80, lvl: 0, cmin: 15, cmax: 17, lat: 264};
    vecs[4] = '{gsel: 1, tap: 0,  half: 0,  lvl: 0, cmin: 0,  cmax: 0,  lat: 520};

    // Reset held with the ring toggling: everything stays zero.
    osc_half = 40;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_outputs", {ring_ena, ring_tap, busy, valid, count}, 0);
      chk("rst_outputs_sat", {ring_ena_s, ring_tap_s, busy_s, valid_s, count_s}, 0);
    end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_outputs", {ring_ena, ring_tap, busy, valid, count}, 0);
    $display("reset phase done");

    // Table-driven measurements.
    foreach (vecs[i]) begin
      osc_static = vecs[i].lvl[0];
      osc_half   = vecs[i].half;
      repeat (4) @(negedge clk);
      launch(vecs[i].gsel, vecs[i].tap, vecs[i].cmin, vecs[i].cmax, t0);
      chk("table_latency_entry", sb[0].lat, vecs[i].lat);
      collect(t0);
    end

    // Busy protection: a second start mid-measurement is ignored.
    osc_half = 40;
    launch(0, 5, 31, 33, t0);
    repeat (99) @(negedge clk);
    start = 1'b1; tap_sel = 4'd9; gate_sel = 3'd7;
    @(negedge clk);
    start = 1'b0;
    chk("busy_ignore_tap", ring_tap, 5);
    chk("busy_ignore_busy", busy, 1);
    collect(t0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!valid || busy) bad++;
    end
    chk("valid_held_no_restart", bad, 0);
    chk("held_ring_tap", ring_tap, 5);
    $display("busy protection done");

    // Reset mid-gate: outputs clear immediately, then a new run is nominal.
    launch(0, 5, 31, 33, t0);
    repeat (150) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {ring_ena, ring_tap, busy, valid, count}, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_idle", {ring_ena, busy, valid}, 0);
    launch(0, 5, 31, 33, t0);
    collect(t0);
    $display("mid-gate reset done");

    // Saturation: 64 edges into a 6-bit counter.
    osc_half = 20;
    repeat (4) @(negedge clk);
    @(negedge clk);
    gate_sel_s = 3'd0; tap_sel_s = 4'd2; start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    t0 = cyc;
    got = 0;
    lat = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (valid_s) begin
        got = 1;
        lat = cyc - t0;
        break;
      end
    end
    if (!got) begin
      errors++;
      $display("FAIL sat_timeout: got no valid expected valid within 300 cycles");
    end else begin
      chk("sat_latency", lat, 264);
      chk("sat_count", count_s, 63);
      chk("sat_ring_tap", ring_tap_s, 2);
      chk("sat_busy", busy_s, 0);
      $display("sat meas count=%0d latency=%0d", count_s, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
